input_shift_register: RTL

Input shift register (ISR) for one PIO state machine. It is the receive-side counterpart of output_shift_register. It shifts 1–32 bits per cycle from the pin/source bus into a 32-bit ISR and tracks the bit count. Via autopush or an explicit PUSH, it delivers the ISR word into the RX fifo (fifo data_in/push_en), stalling the state machine while the fifo is full.

---
 rtl/input_shift_register.sv | 116 +++++++++++
 1 files changed

// File: rtl/input_shift_register.sv
// Receive-side shift register for one PIO state machine: shifts pin data into a
// 32-bit ISR, tracks the bit count and hands full words to the RX fifo.
module input_shift_register (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_in,
    input  logic        shift_en,
    input  logic [4:0]  shift_count,
    input  logic        shiftdir,
    input  logic        autopush,
    input  logic [4:0]  push_thresh,
    input  logic        push_req,
    input  logic        push_block,
    input  logic        mov_en,
    input  logic [31:0] mov_in,
    output logic [31:0] mov_out,
    input  logic        fifo_full,
    output logic        fifo_push,
    output logic [31:0] fifo_data,
    output logic        stall,
    output logic [5:0]  input_shift_counter
);

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] isr_reg, isr_next;
    logic [5:0]  cnt_reg, cnt_next;

    logic [5:0]  shift_n;
    logic [5:0]  thresh_n;
    logic [6:0]  cnt_sum;
    logic [5:0]  cnt_sat;
    logic [31:0] data_mask;
    logic [63:0] right_cat;
    logic [63:0] left_cat;
    logic [31:0] isr_shifted;

    // A 5-bit field of zero means a full 32-bit shift or threshold.
    assign shift_n  = (shift_count == 5'd0) ? 6'd32 : {1'b0, shift_count};
    assign thresh_n = (push_thresh == 5'd0) ? 6'd32 : {1'b0, push_thresh};

    assign cnt_sum = {1'b0, cnt_reg} + {1'b0, shift_n};
    assign cnt_sat = (cnt_sum > 7'd32) ? 6'd32 : cnt_sum[5:0];

    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_mask
            assign data_mask[gi] = (6'(gi) < shift_n);
        end
    endgenerate

    // Right shift: low n bits of data_in land on top, isr slides down.
    assign right_cat = {data_in, isr_reg} >> shift_n;
    // Left shift: isr slides up, low n bits of data_in fill the bottom.
    assign left_cat  = {32'd0, isr_reg} << shift_n;

    assign isr_shifted = shiftdir ? right_cat[31:0]
                                  : (left_cat[31:0] | (data_in & data_mask));

    always_comb begin
        state_next = state_reg;
        isr_next   = isr_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (mov_en) begin
                    isr_next = mov_in;
                    cnt_next = 6'd0;
                end else if (shift_en) begin
                    isr_next = isr_shifted;
                    cnt_next = cnt_sat;
                    if (autopush && (cnt_sat >= thresh_n))
                        state_next = PENDING;
                end else if (push_req) begin
                    if (push_block || !fifo_full) begin
                        state_next = PENDING;
                    end else begin
                        isr_next = 32'd0;
                        cnt_next = 6'd0;
                    end
                end
            end
            PENDING: begin
                if (!fifo_full) begin
                    isr_next   = 32'd0;
                    cnt_next   = 6'd0;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            isr_reg   <= 32'd0;
            cnt_reg   <= 6'd0;
        end else begin
            state_reg <= state_next;
            isr_reg   <= isr_next;
            cnt_reg   <= cnt_next;
        end
    end

    // The fifo captures on the same edge that clears the ISR.
    assign fifo_push           = (state_reg == PENDING) && !fifo_full;
    assign stall               = (state_reg == PENDING);
    assign fifo_data           = isr_reg;
    assign mov_out             = isr_reg;
    assign input_shift_counter = cnt_reg;

endmodule
